// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-network datapath: default widths, the
// window-length helper and the encoder state encoding.
package snn_pkg;

  localparam int DEF_TIMER_WIDTH = 5;
  localparam int DEF_NUM_LANES   = 3;

  // A window spans every nonzero value of a timer: 2**tw - 1 timesteps.
  function automatic int window_of(input int tw);
    return (1 << tw) - 1;
  endfunction

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } enc_state_t;

endpackage

// File: rtl/spike_rate_lane.sv
// One encoder lane: an error accumulator that fires whenever the running sum
// of the held count crosses the window length, spreading count spikes evenly.
module spike_rate_lane
  import snn_pkg::*;
#(
  parameter int TIMER_WIDTH = DEF_TIMER_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic                   step,
  input  logic [TIMER_WIDTH-1:0] count_in,
  output logic                   fire
);

  localparam int WINDOW = window_of(TIMER_WIDTH);
  localparam logic [TIMER_WIDTH:0] WIN_W = (TIMER_WIDTH+1)'(WINDOW);

  logic [TIMER_WIDTH-1:0] count;
  logic [TIMER_WIDTH-1:0] acc;
  logic [TIMER_WIDTH:0]   sum;
  logic [TIMER_WIDTH:0]   wrapped;

  // acc < WINDOW and count <= WINDOW, so one extra bit holds the sum.
  assign sum     = {1'b0, acc} + {1'b0, count};
  assign fire    = (sum >= WIN_W);
  assign wrapped = sum - WIN_W;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      acc   <= '0;
    end else if (load) begin
      count <= count_in;
      acc   <= '0;
    end else if (step) begin
      acc <= fire ? wrapped[TIMER_WIDTH-1:0] : sum[TIMER_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/spike_train_encoder.sv
// Re-emits per-lane spike counts as evenly spaced 1-bit spike trains over a
// window of 2**TIMER_WIDTH-1 timesteps; all lanes step in lockstep.
module spike_train_encoder
  import snn_pkg::*;
#(
  parameter int NUM_LANES   = DEF_NUM_LANES,
  parameter int TIMER_WIDTH = DEF_TIMER_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [NUM_LANES*TIMER_WIDTH-1:0] spike_counts,
  input  logic                             step_en,
  output logic [NUM_LANES-1:0]             spikes,
  output logic                             spike_valid,
  output logic [TIMER_WIDTH-1:0]           timestep,
  output logic                             window_done
);

  localparam int WINDOW = window_of(TIMER_WIDTH);
  localparam logic [TIMER_WIDTH-1:0] LAST_T = TIMER_WIDTH'(WINDOW - 1);

  enc_state_t             state;
  logic [TIMER_WIDTH-1:0] t;
  logic [NUM_LANES-1:0]   fire;
  logic                   load;
  logic                   step;

  // Handshake: a count vector transfers on a rising edge where in_valid and
  // in_ready are both high; in_ready depends on state only, and in_valid is
  // ignored while a window is running.
  assign in_ready = (state == IDLE);
  assign load     = in_valid && in_ready;
  assign step     = (state == RUN) && step_en;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    spike_rate_lane #(
      .TIMER_WIDTH(TIMER_WIDTH)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .step     (step),
      .count_in (spike_counts[g*TIMER_WIDTH +: TIMER_WIDTH]),
      .fire     (fire[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      t           <= '0;
      spikes      <= '0;
      spike_valid <= 1'b0;
      timestep    <= '0;
      window_done <= 1'b0;
    end else begin
      spikes      <= '0;
      spike_valid <= 1'b0;
      timestep    <= '0;
      window_done <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            t     <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (step_en) begin
            spikes      <= fire;
            spike_valid <= 1'b1;
            timestep    <= t;
            t           <= t + 1'b1;
            if (t == LAST_T) begin
              window_done <= 1'b1;
              state       <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spike_train_encoder.sv
// Self-checking bench for spike_train_encoder: an arithmetic rate model feeds
// an expected queue that the output monitor drains on every valid timestep.
module tb_spike_train_encoder;

  localparam int NL  = 3;
  localparam int TW  = 5;
  localparam int WIN = 31;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [NL*TW-1:0]  spike_counts = '0;
  logic              step_en = 1'b0;
  logic [NL-1:0]     spikes;
  logic              spike_valid;
  logic [TW-1:0]     timestep;
  logic              window_done;

  logic [TW+NL:0]    exp_q[$];
  int                hits[NL][$];
  int                n_checks = 0;
  int                n_errors = 0;

  spike_train_encoder #(.NUM_LANES(NL), .TIMER_WIDTH(TW)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .spike_counts (spike_counts),
    .step_en      (step_en),
    .spikes       (spikes),
    .spike_valid  (spike_valid),
    .timestep     (timestep),
    .window_done  (window_done)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // ---------------- model ----------------
  // Lane with count c spikes at step k exactly when floor((k+1)c/W) steps past floor(kc/W).
  task automatic push_model(input logic [NL*TW-1:0] v);
    for (int k = 0; k < WIN; k++) begin
      logic [NL-1:0] s;
      for (int i = 0; i < NL; i++) begin
        int c;
        c = int'(v[i*TW +: TW]);
        s[i] = (((k + 1) * c) / WIN) != ((k * c) / WIN);
      end
      exp_q.push_back({(k == WIN - 1), TW'(k), s});
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (spike_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", {23'd0, window_done, timestep, spikes}, 32'hFFFF_FFFF);
        end else begin
          logic [TW+NL:0] e;
          e = exp_q.pop_front();
          check("step_output", {23'd0, window_done, timestep, spikes}, {23'd0, e});
        end
        for (int i = 0; i < NL; i++) if (spikes[i]) hits[i].push_back(int'(timestep));
      end else begin
        check("stall_zero", {23'd0, window_done, timestep, spikes}, 32'd0);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic clear_hits();
    for (int i = 0; i < NL; i++) hits[i].delete();
  endtask

  task automatic send(input logic [NL*TW-1:0] v, output int waited);
    in_valid = 1'b1;
    spike_counts = v;
    waited = 0;
    while (!in_ready && waited < 100) begin
      tick();
      waited++;
    end
    check("send_ready", {31'd0, in_ready}, 32'd1);
    push_model(v);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic run_window(input bit rnd_step, input bit poke);
    int n = 0;
    bit done = 1'b0;
    while (!done && n < 400) begin
      step_en = rnd_step ? 1'($urandom_range(0, 1)) : 1'b1;
      if (poke) begin
        in_valid = 1'($urandom_range(0, 1));
        spike_counts = NL*TW'($urandom);
      end
      tick();
      n++;
      if (window_done) done = 1'b1;
    end
    if (poke) in_valid = 1'b0;
    step_en = 1'b1;
    check("window_done_seen", {31'd0, done}, 32'd1);
  endtask

  task automatic check_counts(input string tag, input logic [NL*TW-1:0] v);
    for (int i = 0; i < NL; i++)
      check(tag, hits[i].size(), int'(v[i*TW +: TW]));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w;
    logic [NL*TW-1:0] va, vb;

    tick();
    tick();
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    check("rst_outputs", {23'd0, spike_valid, window_done, timestep, spikes}, 32'd0);
    rst = 1'b0;
    step_en = 1'b1;
    tick();

    // Extremes: zero, full-rate and single-spike lanes.
    va = {5'd1, 5'd31, 5'd0};
    clear_hits();
    send(va, w);
    run_window(1'b0, 1'b0);
    tick();
    check_counts("extreme_count", va);
    if (hits[2].size() > 0) check("single_spike_t", hits[2][0], 30);

    // Half rate on all lanes: evenly spaced, first spike at timestep 1.
    va = {5'd16, 5'd16, 5'd16};
    clear_hits();
    send(va, w);
    run_window(1'b0, 1'b0);
    tick();
    check_counts("half_count", va);
    for (int i = 0; i < NL; i++) begin
      int gmin = 99, gmax = 0;
      if (hits[i].size() > 0) check("half_first", hits[i][0], 1);
      for (int j = 1; j < hits[i].size(); j++) begin
        int g;
        g = hits[i][j] - hits[i][j-1];
        if (g < gmin) gmin = g;
        if (g > gmax) gmax = g;
      end
      check("half_gap_spread", {31'd0, (gmax - gmin) <= 1}, 32'd1);
    end

    // Random stalls must not change the spike sequence.
    va = {5'd31, 5'd20, 5'd7};
    clear_hits();
    send(va, w);
    run_window(1'b1, 1'b0);
    tick();
    check_counts("stall_count", va);

    // in_valid held through a window: second vector taken on the first ready cycle.
    va = {5'd9, 5'd5, 5'd3};
    vb = {5'd17, 5'd2, 5'd30};
    in_valid = 1'b1;
    spike_counts = va;
    check("hold_ready", {31'd0, in_ready}, 32'd1);
    push_model(va);
    tick();
    spike_counts = vb;
    run_window(1'b0, 1'b0);
    check("hold_ready_back", {31'd0, in_ready}, 32'd1);
    push_model(vb);
    tick();
    check("hold_accepted", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    spike_counts = '0;
    run_window(1'b1, 1'b0);

    // in_valid pulses with junk counts during RUN are ignored.
    va = {5'd25, 5'd0, 5'd11};
    tick();
    send(va, w);
    run_window(1'b1, 1'b1);

    // Back-to-back windows: next vector accepted right as in_ready returns.
    va = {5'd4, 5'd28, 5'd13};
    vb = {5'd19, 5'd8, 5'd26};
    tick();
    send(va, w);
    run_window(1'b0, 1'b0);
    check("b2b_ready", {31'd0, in_ready}, 32'd1);
    send(vb, w);
    check("b2b_no_wait", w, 0);
    run_window(1'b0, 1'b0);

    // Reset in the middle of a window at timestep 10.
    va = {5'd12, 5'd31, 5'd6};
    tick();
    send(va, w);
    begin
      int n = 0;
      while (!(spike_valid && timestep == TW'(10)) && n < 100) begin
        tick();
        n++;
      end
      check("reached_t10", {31'd0, spike_valid && timestep == TW'(10)}, 32'd1);
    end
    #2;
    rst = 1'b1;
    #1;
    check("midrst_outputs", {23'd0, spike_valid, window_done, timestep, spikes}, 32'd0);
    check("midrst_ready", {31'd0, in_ready}, 32'd1);
    exp_q.delete();
    tick();
    rst = 1'b0;
    check("post_rst_ready", {31'd0, in_ready}, 32'd1);

    // Recovery window with random counts.
    for (int i = 0; i < NL; i++) va[i*TW +: TW] = TW'($urandom_range(0, WIN));
    clear_hits();
    send(va, w);
    run_window(1'b1, 1'b0);
    tick();
    check_counts("recover_count", va);

    tick();
    check("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
